uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Serial transmit stage of the UART: accepts one 8-bit character plus the parity bit produced by the parity stage and serializes it onto the TX line. The frame is a start bit, 8 data bits LSB-first, an optional parity bit and 1 or 2 stop bits. Bit timing comes from an internal clock-divider tick. The block sits directly downstream of the parity calculator and drives the UART pin.

## Interface
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit; legal range ≥ 2.
- `clk` input 1: system clock; all state changes on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `tx_start` input 1: single-cycle request to send; honoured only when `busy`=0.
- `data_in` input 8: character to send.
- `parity_type` input 2: 2'b01 odd, 2'b10 even; 2'b00/2'b11 mean no parity bit in the frame.
- `parity_bit` input 1: parity value from the parity stage, valid with `data_in`.
- `stop2` input 1: 0 = one stop bit, 1 = two stop bits.
- `tx_out` output 1: serial line, idle high.
- `busy` output 1: frame in progress.
- `done` output 1: one-cycle pulse at frame completion.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `tx_out`=1, `busy`=0.
  - `tx_start`=1 loads `data_in`, `parity_type`, `parity_bit` and `stop2` into shadow registers.
  - The same cycle restarts the bit divider and goes to START.
  - Inputs may change after the load without effect.
- START: `tx_out`=0 for one bit period, then DATA.
- DATA: `tx_out`=shift[0]; shift right on each bit tick; 3-bit index counts 0..7. After bit 7 go to PARITY if parity is enabled, else STOP.
- PARITY: `tx_out`=latched `parity_bit` for one bit period, then STOP. Odd/even selects only whether the slot exists; the value always comes from `parity_bit`.
- STOP: `tx_out`=1 for 1 or 2 bit periods per latched `stop2`, then IDLE with `done`=1.
- `tx_start` while `busy`=1 is ignored: no queuing, no effect on the current frame.
- Bit divider: counter runs 0..CLKS_PER_BIT-1. The bit tick fires at CLKS_PER_BIT-1, then the counter wraps to 0. It is held at 0 in IDLE and cleared on load.

## Timing
- Reset values: `tx_out`=1, `busy`=0, `done`=0, state IDLE, all counters and shadow registers 0.
- `tx_start` sampled high at edge N: from N+1, `tx_out`=0 and `busy`=1.
- Frame duration: (1 + 8 + P + S) × CLKS_PER_BIT cycles, where P ∈ {0,1} and S ∈ {1,2}. Each bit holds exactly CLKS_PER_BIT cycles.
- Completion: in the cycle after the last stop-bit period, `done`=1 and `busy`=0.
- `tx_start` accepted in the `done` cycle gives back-to-back frames: the start bit begins on the next cycle, with no idle bit between frames.
- Reset mid-frame: all outputs return immediately to their reset values; no `done` pulse for the aborted frame.
- `tx_out` is driven from a register (glitch-free); there is no combinational path from inputs to `tx_out`.

## Structure
- Shared UART package holds:
  - the parity encodings `PAR_ODD`=2'b01 and `PAR_EVEN`=2'b10,
  - the state enum `tx_state_t`,
  - the `DATA_BITS`=8 constant.
- One sub-module: `uart_baud_tick`.
  - Parameter: `CLKS_PER_BIT`.
  - Inputs: `clk`, `rst_n`, `clear`, `enable`.
  - Output: `tick`.
  - Used by the RX side as well.

## Test plan
All runs use CLKS_PER_BIT=4.
- **Even parity, one stop:** `data_in`=8'h55, `parity_type`=2'b10, `parity_bit`=0, `stop2`=0 → `tx_out` bits 0,1,0,1,0,1,0,1,0,0,1, each 4 cycles; `done` 44 cycles after the start bit begins.
- **No parity, two stops:** `data_in`=8'h80, `parity_type`=2'b00, `stop2`=1 → bits 0, seven 0s, 1, 1, 1 (11 bits); `done` after 44 cycles; no parity slot.
- **Odd parity:** `data_in`=8'hFF, `parity_type`=2'b01, `parity_bit`=1 → parity slot is 1; frame is 11 bits, 44 cycles.
- **Start while busy:** `tx_start` with 8'hAA mid-frame of 8'h55 → the 8'h55 frame is unchanged, no second frame, a single `done`.
- **Back-to-back:** `tx_start` (8'h0F) in the `done` cycle → next cycle `tx_out`=0, `busy` stays 1 after one low cycle in the `done` cycle, no idle-high bit between frames.
- **Reset mid-frame:** `rst_n` low during DATA bit 3 → `tx_out`=1, `busy`=0 immediately, no `done`. After release, a fresh 8'h55 frame matches the first scenario exactly.

Source files
------------

// File: rtl/uart_tx_frame_pkg.sv
// Shared UART definitions: parity encodings, transmit state encoding and
// character width, used by both the TX frame and the RX side.
package uart_tx_frame_pkg;

    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam int         DATA_BITS = 8;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    // A parity slot exists only for the odd/even encodings; 00 and 11 omit it.
    function automatic logic parity_enabled(input logic [1:0] ptype);
        return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Character request / status bundle between the parity stage (master side)
// and the serial transmit frame (slave side), including the TX pin.
interface uart_tx_frame_if;
    import uart_tx_frame_pkg::*;

    logic                 tx_start;
    logic [DATA_BITS-1:0] data_in;
    logic [1:0]           parity_type;
    logic                 parity_bit;
    logic                 stop2;
    logic                 tx_out;
    logic                 busy;
    logic                 done;

    modport master (
        output tx_start, data_in, parity_type, parity_bit, stop2,
        input  tx_out, busy, done
    );

    modport slave (
        input  tx_start, data_in, parity_type, parity_bit, stop2,
        output tx_out, busy, done
    );

endinterface

// File: rtl/uart_tx_frame_baud_tick.sv
// Bit-period divider shared by the UART TX and RX paths. The counter runs
// 0..CLKS_PER_BIT-1 while enabled and issues a tick on its last count.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Count bit-period cycles; parked at zero when idle or being restarted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || !enable) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = enable && !clear && (cnt == CNT_MAX);

endmodule

// File: rtl/uart_tx_frame.sv
// UART serial transmitter: start bit, 8 data bits LSB-first, optional parity
// slot and 1 or 2 stop bits. All frame settings are captured at load so the
// upstream stage may move on immediately. tx_out is a register output.
module uart_tx_frame
    import uart_tx_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_frame_if.slave  bus
);

    localparam logic [2:0] ST_IDLE   = TX_IDLE;
    localparam logic [2:0] ST_START  = TX_START;
    localparam logic [2:0] ST_DATA   = TX_DATA;
    localparam logic [2:0] ST_PARITY = TX_PARITY;
    localparam logic [2:0] ST_STOP   = TX_STOP;
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    logic [2:0]           state;
    logic [DATA_BITS-1:0] shift;
    logic [2:0]           bit_idx;
    logic                 stop_cnt;
    logic [1:0]           sh_ptype;
    logic                 sh_pbit;
    logic                 sh_stop2;
    logic                 tx_out_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 load;
    logic                 bit_tick;

    // A request is only honoured from IDLE (which includes the done cycle).
    assign load = (state == ST_IDLE) && bus.tx_start;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (load),
        .enable (state != ST_IDLE),
        .tick   (bit_tick)
    );

    // Frame sequencer: next-state, shift register and registered line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            sh_ptype <= '0;
            sh_pbit  <= 1'b0;
            sh_stop2 <= 1'b0;
            tx_out_r <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.tx_start) begin
                        shift    <= bus.data_in;
                        sh_ptype <= bus.parity_type;
                        sh_pbit  <= bus.parity_bit;
                        sh_stop2 <= bus.stop2;
                        bit_idx  <= '0;
                        stop_cnt <= 1'b0;
                        tx_out_r <= 1'b0;
                        busy_r   <= 1'b1;
                        state    <= ST_START;
                    end else begin
                        tx_out_r <= 1'b1;
                        busy_r   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        tx_out_r <= shift[0];
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == LAST_BIT) begin
                            if (parity_enabled(sh_ptype)) begin
                                tx_out_r <= sh_pbit;
                                state    <= ST_PARITY;
                            end else begin
                                tx_out_r <= 1'b1;
                                state    <= ST_STOP;
                            end
                        end else begin
                            tx_out_r <= shift[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        tx_out_r <= 1'b1;
                        state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        if (sh_stop2 && !stop_cnt) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            tx_out_r <= 1'b1;
                            busy_r   <= 1'b0;
                            done_r   <= 1'b1;
                            state    <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    tx_out_r <= 1'b1;
                    busy_r   <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_out = tx_out_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame with CLKS_PER_BIT=4. The driver pushes
// the hand-computed bit sequence of each frame; the monitor captures tx_out
// for every busy cycle and compares the whole waveform when done pulses.
module tb_uart_tx_frame;
    import uart_tx_frame_pkg::*;

    localparam int CPB = 4;

    typedef struct {
        logic [11:0] bits;   // bit i = i-th bit on the line (start bit = bit 0)
        int          len;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_frame_if bus();

    uart_tx_frame #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   n_checks    = 0;
    int   n_fail      = 0;
    int   frames_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: record line level over each busy stretch, score on done.
    initial begin : monitor
        logic        wave [0:63];
        int          cyc;
        logic        in_frame;
        exp_t        e;
        logic [47:0] act_w;
        logic [47:0] exp_w;
        in_frame = 1'b0;
        cyc      = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 1'b0;
                cyc      = 0;
            end else if (bus.done) begin
                if (!in_frame) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    frames_seen++;
                    chk("done_busy_low", bus.busy, 0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 1, 0);
                    end else begin
                        e     = exp_q.pop_front();
                        act_w = '0;
                        exp_w = '0;
                        for (int i = 0; i < 48; i++) begin
                            if (i < cyc)         act_w[i] = wave[i];
                            if (i < e.len * CPB) exp_w[i] = e.bits[i / CPB];
                        end
                        chk("frame_cycles", 64'(cyc), 64'(e.len * CPB));
                        chk("frame_wave", 64'(act_w), 64'(exp_w));
                    end
                end
                in_frame = 1'b0;
                cyc      = 0;
            end else if (bus.busy) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    cyc      = 0;
                end
                if (cyc < 64) wave[cyc] = bus.tx_out;
                cyc++;
                if (cyc > 60) begin
                    chk("frame_overrun", 1, 0);
                    in_frame = 1'b0;
                    cyc      = 0;
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("done_timeout", 1, 0);
    endtask

    // Issue one request at a negedge, then scramble inputs to show they are latched.
    task automatic issue(input logic [7:0] d, input logic [1:0] pt, input logic pb,
                         input logic s2, input logic [11:0] bits, input int len,
                         input string tag);
        exp_t e;
        e.bits = bits;
        e.len  = len;
        bus.data_in     = d;
        bus.parity_type = pt;
        bus.parity_bit  = pb;
        bus.stop2       = s2;
        bus.tx_start    = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.tx_start    = 1'b0;
        bus.data_in     = ~d;
        bus.parity_type = ~pt;
        bus.parity_bit  = ~pb;
        bus.stop2       = ~s2;
        chk({tag, "_tx_low"}, bus.tx_out, 0);
        chk({tag, "_busy"}, bus.busy, 1);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] pt, input logic pb,
                        input logic s2, input logic [11:0] bits, input int len);
        wait_idle();
        issue(d, pt, pb, s2, bits, len, "start");
    endtask

    initial begin : driver
        bus.tx_start    = 1'b0;
        bus.data_in     = '0;
        bus.parity_type = '0;
        bus.parity_bit  = 1'b0;
        bus.stop2       = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_tx_out", bus.tx_out, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_tx_out", bus.tx_out, 1);
        chk("idle_busy", bus.busy, 0);

        // 0x55, even parity slot (value 0), one stop
        send(8'h55, PAR_EVEN, 1'b0, 1'b0, 12'b0100_1010_1010, 11);
        // request while busy must be ignored
        repeat (12) @(negedge clk);
        bus.data_in  = 8'hAA;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        chk("busy_hold", bus.busy, 1);

        // 0x80, no parity, two stops (parity_bit must not appear)
        send(8'h80, 2'b00, 1'b1, 1'b1, 12'b0111_0000_0000, 11);
        // 0xFF, odd parity slot carrying 1
        send(8'hFF, PAR_ODD, 1'b1, 1'b0, 12'b0111_1111_1110, 11);
        // 0x3C, even parity slot 0, two stops: longest frame
        send(8'h3C, PAR_EVEN, 1'b0, 1'b1, 12'b1100_0111_1000, 12);
        // 0xA5, encoding 11 means no parity slot
        send(8'hA5, 2'b11, 1'b1, 1'b0, 12'b0011_0100_1010, 10);

        // back-to-back: 0x0F requested in the done cycle of a 0x55 frame
        send(8'h55, PAR_EVEN, 1'b0, 1'b0, 12'b0100_1010_1010, 11);
        wait_done();
        chk("b2b_done_busy", bus.busy, 0);
        issue(8'h0F, 2'b00, 1'b0, 1'b0, 12'b0010_0001_1110, 10, "b2b");

        // reset during data bit 3 of a 0x55 frame
        send(8'h55, PAR_EVEN, 1'b0, 1'b0, 12'b0100_1010_1010, 11);
        repeat (17) @(negedge clk);
        chk("pre_rst_busy", bus.busy, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_tx_out", bus.tx_out, 1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // fresh frame after reset matches the first scenario
        send(8'h55, PAR_EVEN, 1'b0, 1'b0, 12'b0100_1010_1010, 11);
        wait_idle();
        repeat (4) @(negedge clk);

        chk("queue_empty", 64'(exp_q.size()), 0);
        chk("frames_seen", 64'(frames_seen), 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
